// File: rtl/avg_pkg.sv
// Shared constants and width helpers for the parametrised fixed-point averager.
package avg_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int calc_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int calc_sw(input int w, input int n);
        return w + clog2(n);
    endfunction

    function automatic int calc_r(input int w);
        return w + 4;
    endfunction

    // Operand count remaining after `lvl` pairwise levels (odd leftovers carried).
    function automatic int lvl_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // round(2^r / n), half rounded up.
    function automatic longint unsigned calc_recip(input int r, input int n);
        longint unsigned num;
        num = (64'd1 << r) + 64'(n / 2);
        return num / 64'(n);
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/average_pipeline_param_if.sv
// Sample-set in / mean out bundle for the averager; master drives operands.
interface average_pipeline_param_if #(
    parameter int W    = 14,
    parameter int N_IN = 3
);
    logic              in_valid;
    logic [N_IN*W-1:0] in_data;
    logic [W-1:0]      avg;
    logic              out_valid;
    logic              sat;

    modport master (output in_valid, output in_data,
                    input avg, input out_valid, input sat);
    modport slave  (input in_valid, input in_data,
                    output avg, output out_valid, output sat);
endinterface

// File: rtl/avg_adder_level.sv
// One registered adder-tree level: pairwise sign-extended sums, odd operand carried.
module avg_adder_level #(
    parameter int N_OP = 3,
    parameter int WI   = 14
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_OP*WI-1:0]                   din,
    output logic [((N_OP+1)/2)*(WI+1)-1:0]       dout
);
    localparam int NO = (N_OP + 1) / 2;
    localparam int WO = WI + 1;

    logic [NO*WO-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int k = 0; k < N_OP / 2; k++) begin
            nxt[k*WO +: WO] = {din[(2*k)*WI + WI - 1],   din[(2*k)*WI +: WI]}
                            + {din[(2*k+1)*WI + WI - 1], din[(2*k+1)*WI +: WI]};
        end
        // Leftover operand keeps its value so every path has the same depth.
        if (N_OP % 2 == 1) begin
            nxt[(NO-1)*WO +: WO] = {din[N_OP*WI - 1], din[(N_OP-1)*WI +: WI]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else     dout <= nxt;
    end
endmodule

// File: rtl/average_pipeline_param.sv
// Pipelined mean of N_IN signed fixed-point samples: adder tree, reciprocal scale, round/saturate.
module average_pipeline_param
    import avg_pkg::*;
#(
    parameter int INT_BITS  = 6,
    parameter int FRAC_BITS = 8,
    parameter int N_IN      = 3
) (
    input logic clk,
    input logic rst,
    average_pipeline_param_if.slave bus
);
    localparam int W  = calc_w(INT_BITS, FRAC_BITS);
    localparam int L  = clog2(N_IN);
    localparam int SW = calc_sw(W, N_IN);
    localparam int R  = calc_r(W);
    localparam int PW = SW + R + 1;
    localparam int QW = PW + 1 - R;
    localparam logic [R:0] RECIP_V = (R+1)'(calc_recip(R, N_IN));
    localparam logic signed [QW-1:0] Q_MAX = QW'(sat_max(W));
    localparam logic signed [QW-1:0] Q_MIN = QW'(sat_min(W));

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int NI = lvl_cnt(N_IN, j);
        localparam int NO = lvl_cnt(N_IN, j + 1);
        localparam int WI = W + j;
        logic [NI*WI-1:0]     din;
        logic [NO*(WI+1)-1:0] dout;
        if (j == 0) begin : g_first
            assign din = bus.in_data;
        end else begin : g_next
            assign din = g_lvl[j-1].dout;
        end
        avg_adder_level #(.N_OP(NI), .WI(WI)) u_level (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .dout (dout)
        );
    end

    logic [SW-1:0]          sum;
    logic [L:0]             vld_sr;
    logic signed [PW+1:0]   prod_full;
    logic signed [PW-1:0]   prod_q;
    logic signed [PW:0]     rnd;
    logic signed [QW-1:0]   q;

    assign sum = g_lvl[L-1].dout;

    // Both operands widened to the product width so the multiply is plainly signed.
    assign prod_full = $signed({{(R+2){sum[SW-1]}}, sum}) * $signed({{(SW+1){1'b0}}, RECIP_V});

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            prod_q <= '0;
        end else begin
            vld_sr <= {vld_sr[L-1:0], bus.in_valid};
            prod_q <= prod_full[PW-1:0];
        end
    end

    assign rnd = {prod_q[PW-1], prod_q} + (PW+1)'(64'd1 << (R - 1));
    assign q   = QW'(rnd >>> R);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.avg       <= '0;
            bus.sat       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= vld_sr[L];
            if (q > Q_MAX) begin
                bus.avg <= Q_MAX[W-1:0];
                bus.sat <= 1'b1;
            end else if (q < Q_MIN) begin
                bus.avg <= Q_MIN[W-1:0];
                bus.sat <= 1'b1;
            end else begin
                bus.avg <= q[W-1:0];
                bus.sat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_average_pipeline_param.sv
// Directed bench for the averager: N_IN=3 and N_IN=4 instances on a shared clock/reset.
module tb_average_pipeline_param;
    localparam int W = 14;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    average_pipeline_param_if #(.W(W), .N_IN(3)) bus3 ();
    average_pipeline_param_if #(.W(W), .N_IN(4)) bus4 ();

    average_pipeline_param #(.INT_BITS(6), .FRAC_BITS(8), .N_IN(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    average_pipeline_param #(.INT_BITS(6), .FRAC_BITS(8), .N_IN(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Independent model: mean of three signed samples rounded half toward +inf, then clamped.
    function automatic logic [W-1:0] mean3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        int s;
        int m;
        s = int'($signed(a)) + int'($signed(b)) + int'($signed(c));
        m = floor_div(2 * s + 3, 6);
        if (m > 8191)  m = 8191;
        if (m < -8192) m = -8192;
        return W'(m);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_data = '0;
        bus4.in_valid = 1'b0; bus4.in_data = '0;
        tick(); tick();
        checks++; if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got %b want 0", bus3.out_valid); end
        checks++; if (bus3.avg !== 14'h0000) begin errors++; $display("FAIL reset_avg3 got %h want 0000", bus3.avg); end
        checks++; if (bus3.sat !== 1'b0) begin errors++; $display("FAIL reset_sat3 got %b want 0", bus3.sat); end
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got %b want 0", bus4.out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_basic_latency();
        bus3.in_data  = {14'h0100, 14'h0100, 14'h3F00};
        bus3.in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin bus3.in_valid = 1'b0; bus3.in_data = '0; end
            checks++;
            if (bus3.out_valid !== (k == 4)) begin
                errors++; $display("FAIL basic_latency cycle %0d out_valid got %b want %b", k, bus3.out_valid, (k == 4));
            end
            if (k == 4) begin
                checks++; if (bus3.avg !== 14'h0055) begin errors++; $display("FAIL basic_avg got %h want 0055", bus3.avg); end
                checks++; if (bus3.sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", bus3.sat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bus3.in_data  = {14'h1FFF, 14'h1FFF, 14'h1FFF};
        bus3.in_valid = 1'b1;
        tick();
        bus3.in_data  = {14'h2000, 14'h2000, 14'h2000};
        tick();
        bus3.in_valid = 1'b0; bus3.in_data = '0;
        tick(); tick();
        checks++; if (bus3.out_valid !== 1'b1 || bus3.avg !== 14'h1FFF || bus3.sat !== 1'b0) begin
            errors++; $display("FAIL b2b_max got v=%b avg=%h sat=%b want v=1 avg=1fff sat=0", bus3.out_valid, bus3.avg, bus3.sat);
        end
        tick();
        checks++; if (bus3.out_valid !== 1'b1 || bus3.avg !== 14'h2000 || bus3.sat !== 1'b0) begin
            errors++; $display("FAIL b2b_min got v=%b avg=%h sat=%b want v=1 avg=2000 sat=0", bus3.out_valid, bus3.avg, bus3.sat);
        end
        tick();
        checks++; if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got %b want 0", bus3.out_valid); end
    endtask

    task automatic test_rounding();
        bus3.in_data  = {14'h0000, 14'h0001, 14'h0001};
        bus3.in_valid = 1'b1;
        tick();
        bus3.in_valid = 1'b0; bus3.in_data = '0;
        tick(); tick(); tick();
        checks++; if (bus3.out_valid !== 1'b1 || bus3.avg !== 14'h0001) begin
            errors++; $display("FAIL round_2over3 got v=%b avg=%h want v=1 avg=0001", bus3.out_valid, bus3.avg);
        end
    endtask

    task automatic test_pow2();
        bus4.in_data  = {14'h0101, 14'h0100, 14'h0100, 14'h0100};
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0; bus4.in_data = '0;
        tick(); tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL pow2_early got %b want 0", bus4.out_valid); end
        tick();
        checks++; if (bus4.out_valid !== 1'b1 || bus4.avg !== 14'h0100 || bus4.sat !== 1'b0) begin
            errors++; $display("FAIL pow2_avg got v=%b avg=%h sat=%b want v=1 avg=0100 sat=0", bus4.out_valid, bus4.avg, bus4.sat);
        end
    endtask

    task automatic test_valid_pattern();
        logic             pat [12] = '{1,0,1,1,0,1,1,0,1,1,0,1};
        logic             exp_v [15];
        logic [W-1:0]     exp_a [15];
        logic [W-1:0]     a, b, c;
        for (int t = 0; t < 15; t++) begin
            if (t < 12) begin
                a = W'($urandom); b = W'($urandom); c = W'($urandom);
                bus3.in_data  = {c, b, a};
                bus3.in_valid = pat[t];
                exp_v[t] = pat[t];
                exp_a[t] = mean3(a, b, c);
            end else begin
                bus3.in_valid = 1'b0; bus3.in_data = '0;
                exp_v[t] = 1'b0;
                exp_a[t] = '0;
            end
            tick();
            if (t >= 3) begin
                checks++;
                if (bus3.out_valid !== exp_v[t-3]) begin
                    errors++; $display("FAIL pattern_valid step %0d got %b want %b", t, bus3.out_valid, exp_v[t-3]);
                end
                if (exp_v[t-3]) begin
                    checks++;
                    if (bus3.avg !== exp_a[t-3]) begin
                        errors++; $display("FAIL pattern_avg step %0d got %h want %h", t, bus3.avg, exp_a[t-3]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            bus3.in_data  = {14'h0300, 14'h0200, 14'h0100};
            bus3.in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus3.in_data  = {14'h0000, 14'h0000, 14'h0300};
        bus3.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin bus3.in_valid = 1'b0; bus3.in_data = '0; end
            if (k < 4) begin
                checks++;
                if (bus3.out_valid !== 1'b0 || bus3.avg !== 14'h0000) begin
                    errors++; $display("FAIL rst_flush cycle %0d got v=%b avg=%h want v=0 avg=0000", k, bus3.out_valid, bus3.avg);
                end
            end else if (k == 4) begin
                checks++;
                if (bus3.out_valid !== 1'b1 || bus3.avg !== 14'h0100) begin
                    errors++; $display("FAIL rst_resume got v=%b avg=%h want v=1 avg=0100", bus3.out_valid, bus3.avg);
                end
            end else begin
                checks++;
                if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_resume_tail got %b want 0", bus3.out_valid); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_rounding();
        test_pow2();
        test_valid_pattern();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
